// File: rtl/out_to_between_tx.sv
// Generic FIFO: registered occupancy, power-of-2 depth, pointers wrap naturally.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: push_rdy = !full from registered occupancy; a full FIFO refuses a push even while popping.
module out_to_between_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_fire, pop_fire;

  assign push_rdy  = (cnt_q != FULL_CNT);
  assign pop_vld   = (cnt_q != '0);
  assign pop_dat   = mem_q[rd_ptr_q];
  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop_rdy && pop_vld;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_fire) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_fire, pop_fire})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy guards every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// Buffered inter-board word sender using a 4-phase tsent/trecieve handshake with watchdog.
// Latency: word pushed into an empty idle block at edge N drives tsent=1 after edge N+1; >=3 cycles/word.
// Backpressure: in_ready drops when DEPTH words are buffered; remote stalls bounded by TIMEOUT per phase.
module out_to_between_tx #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] t_data,
  output logic             tsent,
  input  logic             trecieve,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] sent_count
);
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int WD_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_LAST_I[WD_W-1:0];
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] t_data_q, t_data_d;
  logic             tsent_q, tsent_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] sent_count_q, sent_count_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             head_vld, pop_rdy, wd_expire;
  logic [WIDTH-1:0] head_dat;

  out_to_between_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (in_valid),
    .push_dat (in_data),
    .push_rdy (in_ready),
    .pop_vld  (head_vld),
    .pop_rdy  (pop_rdy),
    .pop_dat  (head_dat)
  );

  assign wd_expire   = WD_EN && (wd_q == WD_LAST);
  assign t_data      = t_data_q;
  assign tsent       = tsent_q;
  assign done        = done_q;
  assign timeout_err = err_q;
  assign sent_count  = sent_count_q;
  assign busy        = (state_q != IDLE) || head_vld;

  // Handshake sequencing; handshake events win over a same-cycle watchdog expiry.
  always_comb begin
    state_d      = state_q;
    t_data_d     = t_data_q;
    tsent_d      = tsent_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    sent_count_d = sent_count_q;
    wd_d         = wd_q + WD_W'(1);
    pop_rdy      = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        // Never start while the remote still acknowledges a previous word.
        if (head_vld && !trecieve) begin
          pop_rdy  = 1'b1;
          t_data_d = head_dat;
          tsent_d  = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (trecieve) begin
          tsent_d = 1'b0;
          wd_d    = '0;
          state_d = RELEASE;
        end else if (wd_expire) begin
          tsent_d  = 1'b0;
          t_data_d = '0;
          err_d    = 1'b1;
          wd_d     = '0;
          state_d  = IDLE;
        end
      end
      RELEASE: begin
        if (!trecieve) begin
          done_d       = 1'b1;
          sent_count_d = sent_count_q + CNT_W'(1);
          t_data_d     = '0;
          wd_d         = '0;
          state_d      = IDLE;
        end else if (wd_expire) begin
          err_d    = 1'b1;
          t_data_d = '0;
          wd_d     = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        wd_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      t_data_q     <= '0;
      tsent_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sent_count_q <= '0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      t_data_q     <= t_data_d;
      tsent_q      <= tsent_d;
      done_q       <= done_d;
      err_q        <= err_d;
      sent_count_q <= sent_count_d;
      wd_q         <= wd_d;
    end
  end
endmodule

// File: tb/tb_out_to_between_tx.sv
// Bench for out_to_between_tx: directed steps plus randomized traffic against a
// remote-board responder and a word-level scoreboard (order, phase lengths,
// outcome per word, counter modulo 2^CNT_W).
module tb_out_to_between_tx;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int TO = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic [W-1:0]  t_data;
  logic          tsent;
  logic          trecieve;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [CW-1:0] sent_count;

  out_to_between_tx #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .t_data      (t_data),
    .tsent       (tsent),
    .trecieve    (trecieve),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .sent_count  (sent_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remote board: acks after cur_ack cycles of seeing tsent, releases after
  // cur_rel cycles of seeing tsent low. Delays are latched when a request appears.
  int ack_dly = 1, rel_dly = 1, cur_ack = 1, cur_rel = 1, hi = 0, lo = 0;
  bit rnd_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      trecieve = 1'b0;
      hi = 0;
      lo = 0;
    end else if (!trecieve) begin
      if (tsent) begin
        if (hi == 0) begin
          if (rnd_mode) begin
            cur_ack = $urandom_range(1, 10);
            cur_rel = $urandom_range(1, 10);
          end else begin
            cur_ack = ack_dly;
            cur_rel = rel_dly;
          end
        end
        hi++;
        if (hi >= cur_ack) begin
          trecieve = 1'b1;
          lo = 0;
        end
      end else begin
        hi = 0;
      end
    end else if (!tsent) begin
      lo++;
      if (lo >= cur_rel) begin
        trecieve = 1'b0;
        hi = 0;
      end
    end
  end

  // Scoreboard: a word succeeds iff both remote phases fit within TIMEOUT cycles;
  // a request lasts min(ack delay, TIMEOUT) cycles.
  logic [W-1:0] mq[$];
  logic [W-1:0] cur_w = '0;
  bit   pend_vld = 1'b0, pend_ok = 1'b0;
  int   exp_len = 0, len = 0, n_done = 0, n_err = 0, exp_cnt = 0;
  logic prev_tsent = 1'b0, prev_trec = 1'b0, prev_done = 1'b0, prev_err = 1'b0, rst_prev = 1'b1;
  always @(negedge clk) begin
    if (reset || rst_prev) begin
      mq.delete();
      pend_vld = 1'b0;
      exp_cnt = 0;
      len = 0;
      prev_tsent = 1'b0;
      prev_done = 1'b0;
      prev_err = 1'b0;
    end else begin
      chk("done_err_excl", done & timeout_err, 0);
      if (!busy) chk("idle_tdata_zero", t_data, 0);
      if (tsent && !prev_tsent) begin
        chk("start_trec_low", prev_trec, 0);
        chk("start_queued", mq.size() > 0, 1);
        if (mq.size() > 0) begin
          cur_w = mq.pop_front();
          chk("word_order", t_data, cur_w);
        end
        pend_vld = 1'b1;
        pend_ok  = (cur_ack <= TO) && (cur_rel <= TO);
        exp_len  = (cur_ack < TO) ? cur_ack : TO;
        len = 0;
      end
      if (tsent) begin
        len++;
        chk("tdata_stable", t_data, cur_w);
      end
      if (!tsent && prev_tsent) chk("tsent_len", len, exp_len);
      if (pend_vld && !tsent && !done && !timeout_err) chk("release_hold", t_data, cur_w);
      if (done) begin
        chk("done_one_cycle", prev_done, 0);
        chk("done_expected", pend_vld && pend_ok, 1);
        pend_vld = 1'b0;
        n_done++;
        exp_cnt++;
        chk("sent_count_step", sent_count, exp_cnt % (1 << CW));
      end
      if (timeout_err) begin
        chk("err_one_cycle", prev_err, 0);
        chk("err_expected", pend_vld && !pend_ok, 1);
        pend_vld = 1'b0;
        n_err++;
      end
      prev_tsent = tsent;
      prev_done = done;
      prev_err = timeout_err;
    end
    prev_trec = trecieve;
    rst_prev = reset;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one word for one cycle; called #1 after an edge.
  task automatic push(input logic [W-1:0] w, output bit acc);
    in_valid = 1'b1;
    in_data  = w;
    acc      = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc) mq.push_back(w);
  endtask

  task automatic push_wait(input logic [W-1:0] w);
    bit acc;
    int g;
    acc = 1'b0;
    g = 0;
    while (!acc && g < 200) begin
      push(w, acc);
      g++;
    end
    if (!acc) chk("push_accept_timeout", acc, 1);
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while ((busy || tsent || trecieve) && g < 4000) begin
      cyc(1);
      g++;
    end
    chk({tag, "_drain"}, g < 4000, 1);
    cyc(2);
  endtask

  int  d0, e0, acc_n, refused, total;
  bit  acc;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    total = 0;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_tsent", tsent, 0);
    chk("rst_tdata", t_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_count", sent_count, 0);

    // Single word with a 2-cycle remote in both phases.
    ack_dly = 2; rel_dly = 2; d0 = n_done; e0 = n_err;
    push(8'hA5, acc);
    chk("single_acc", acc, 1);
    chk("single_lat_edge0", tsent, 0);
    cyc(1);
    chk("single_lat_edge1", tsent, 1);
    chk("single_tdata", t_data, 8'hA5);
    drain("single");
    total += 1;
    chk("single_done", n_done - d0, 1);
    chk("single_err", n_err - e0, 0);
    chk("single_count", sent_count, total % 4);
    chk("single_tdata_after", t_data, 0);

    // Burst into a stalled remote: 5 accepted, sixth refused.
    ack_dly = 7; rel_dly = 1; d0 = n_done; e0 = n_err; acc_n = 0; refused = 0;
    for (int i = 1; i <= 6; i++) begin
      push(W'(i), acc);
      if (acc) acc_n++;
      else refused = i;
    end
    chk("burst_accepted", acc_n, 5);
    chk("burst_refused", refused, 6);
    chk("burst_in_ready", in_ready, 0);
    chk("burst_holding", tsent, 1);
    ack_dly = 1;
    drain("burst");
    total += 5;
    chk("burst_done", n_done - d0, 5);
    chk("burst_err", n_err - e0, 0);
    chk("burst_count", sent_count, total % 4);

    // No ack: request held TIMEOUT cycles, word dropped, next word proceeds.
    ack_dly = 20; rel_dly = 1; d0 = n_done; e0 = n_err;
    push_wait(8'h3C);
    push_wait(8'hC3);
    cyc(1);
    ack_dly = 1;
    drain("to_send");
    total += 1;
    chk("to_send_err", n_err - e0, 1);
    chk("to_send_done", n_done - d0, 1);
    chk("to_send_count", sent_count, total % 4);

    // Ack stuck high: release phase times out, next word waits for the drop.
    ack_dly = 1; rel_dly = 15; d0 = n_done; e0 = n_err;
    push_wait(8'h5A);
    push_wait(8'h96);
    cyc(2);
    rel_dly = 1;
    drain("to_rel");
    total += 1;
    chk("to_rel_err", n_err - e0, 1);
    chk("to_rel_done", n_done - d0, 1);
    chk("to_rel_count", sent_count, total % 4);

    // Reset while a word is in flight with three more buffered.
    ack_dly = 20;
    push_wait(8'h11);
    push_wait(8'h22);
    push_wait(8'h33);
    push_wait(8'h44);
    chk("mid_tsent", tsent, 1);
    chk("mid_busy", busy, 1);
    d0 = n_done; e0 = n_err;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mid_rst_tsent", tsent, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", sent_count, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", timeout_err, 0);
    cyc(12);
    chk("mid_no_done", n_done - d0, 0);
    chk("mid_no_err", n_err - e0, 0);
    chk("mid_idle_tsent", tsent, 0);
    total = 0;
    ack_dly = 1;

    // Counter wrap over five completions: 1,2,3,0,1.
    d0 = n_done;
    for (int i = 0; i < 5; i++) push_wait(W'(8'h70 + i));
    drain("wrap");
    total += 5;
    chk("wrap_done", n_done - d0, 5);
    chk("wrap_count", sent_count, 1);

    // Randomized traffic and remote delays (some beyond the watchdog).
    rnd_mode = 1'b1; d0 = n_done; e0 = n_err;
    for (int i = 0; i < 60; i++) begin
      cyc($urandom_range(0, 3));
      push_wait(W'($urandom));
    end
    drain("rand");
    rnd_mode = 1'b0;
    total += n_done - d0;
    chk("rand_outcomes", (n_done - d0) + (n_err - e0), 60);
    chk("rand_count", sent_count, total % 4);
    chk("rand_queue_empty", mq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
